program_load_sequencer: RTL

//  Controller for the 32x16 instruction memory. Fills the memory from a byte stream
//  (loader mode), then steps the program counter through the program (run mode).
//  Run mode hands each fetched instruction to the execute stage with a valid/ready handshake.

---
 rtl/program_load_sequencer_pkg.sv | 14 +
 rtl/program_load_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/program_load_sequencer_pkg.sv
// program_load_sequencer_pkg: shared widths, opcode field, HALT opcode and FSM encoding
package program_load_sequencer_pkg;
    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 16;
    localparam int LEN_W   = 6;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam logic [3:0] HALT_OP = 4'b1111;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_HI, S_LOAD_LO, S_WRITE, S_RUN, S_DONE} state_t;
    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return len != '0 && len <= LEN_W'(DEPTH);
    endfunction
endpackage

// File: rtl/program_load_sequencer.sv
// program_load_sequencer: fills instruction memory from a byte stream, then issues the program to execute
module program_load_sequencer
    import program_load_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               run_start,
    input  logic [LEN_W-1:0]   run_len,
    input  logic               abort,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               load_instr,
    output logic [ADDR_W-1:0]  load_instr_address,
    output logic [INSTR_W-1:0] instruction_input,
    output logic [ADDR_W-1:0]  program_counter,
    input  logic [INSTR_W-1:0] instruction,
    output logic               exec_valid,
    input  logic               exec_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);
    state_t            r_state;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_count_nx;
    logic [LEN_W-1:0]  w_req_len;
    logic              w_halt;

    assign w_count_nx = r_count + 1'b1;
    assign w_req_len  = load_start ? load_len : run_len;
    assign w_halt     = instruction[OP_HI:OP_LO] == HALT_OP;
    assign byte_ready = r_state == S_LOAD_HI || r_state == S_LOAD_LO;
    assign exec_valid = r_state == S_RUN;

    // Controller FSM; strobes default low, abort overrides every state without writing or signalling done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_hi               <= '0;
            r_addr             <= '0;
            r_count            <= '0;
            r_len              <= '0;
            load_instr         <= 1'b0;
            load_instr_address <= '0;
            instruction_input  <= '0;
            program_counter    <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            load_instr <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (load_start || run_start) begin
                        if (!len_ok(w_req_len)) begin
                            err <= 1'b1;
                        end else begin
                            r_len   <= w_req_len;
                            r_addr  <= '0;
                            r_count <= '0;
                            busy    <= 1'b1;
                            if (load_start) begin
                                r_state <= S_LOAD_HI;
                            end else begin
                                r_state         <= S_RUN;
                                program_counter <= '0;
                            end
                        end
                    end
                    S_LOAD_HI: if (byte_valid) begin
                        r_hi    <= byte_in;
                        r_state <= S_LOAD_LO;
                    end
                    S_LOAD_LO: if (byte_valid) begin
                        instruction_input  <= {r_hi, byte_in};
                        load_instr_address <= r_addr;
                        load_instr         <= 1'b1;
                        r_state            <= S_WRITE;
                    end
                    S_WRITE: begin
                        r_addr  <= r_addr + 1'b1;
                        r_count <= w_count_nx;
                        done    <= w_count_nx == r_len;
                        r_state <= w_count_nx == r_len ? S_DONE : S_LOAD_HI;
                    end
                    S_RUN: if (exec_ready) begin
                        r_count <= w_count_nx;
                        if (w_count_nx == r_len || w_halt) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            program_counter <= program_counter + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
